// File: rtl/sargantana_icache_pkg.sv
// Shared widths, helpers and response payload for the I-cache tag checker pipe.
package sargantana_icache_pkg;

  localparam int unsigned CHK_N_WAY   = 4;
  localparam int unsigned CHK_LINE_W  = 256;
  localparam int unsigned CHK_FETCH_W = 128;

  // Width of an index over n items, never narrower than one bit.
  function automatic int unsigned chk_clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CHK_IDX_W = chk_clog2_min1(CHK_LINE_W / CHK_FETCH_W);
  localparam int unsigned CHK_WAY_W = chk_clog2_min1(CHK_N_WAY);

  typedef struct packed {
    logic                   hit;
    logic                   multihit;
    logic [CHK_WAY_W-1:0]   way;
    logic [CHK_FETCH_W-1:0] data;
  } chk_rsp_t;

  localparam logic [0:0] CHK_EMPTY = 1'b0;
  localparam logic [0:0] CHK_FULL  = 1'b1;

endpackage

// File: rtl/sargantana_icache_way_prio_enc.sv
// Lowest-set-index priority encoder with any/multiple-set flags.
module sargantana_icache_way_prio_enc
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = chk_clog2_min1(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         multi_o
);

  // Scanning downward leaves the lowest set index in idx_o.
  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    multi_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        if (any_o) multi_o = 1'b1;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sargantana_icache_checker_pipe.sv
// I-cache tag checker: way compare, refill bypass, chunk select, one-entry
// valid/ready output register and saturating hit/miss counters.
module sargantana_icache_checker_pipe
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_WAY   = 4,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned FETCH_W = 128,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned IDX_W  = chk_clog2_min1(LINE_W / FETCH_W),
  localparam int unsigned WAY_W  = chk_clog2_min1(N_WAY)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [TAG_W-1:0]          req_tag_i,
  input  logic [IDX_W-1:0]          req_idx_i,
  input  logic [N_WAY-1:0]          way_valid_i,
  input  logic [N_WAY*TAG_W-1:0]    rd_tags_i,
  input  logic [N_WAY*LINE_W-1:0]   rd_data_i,
  input  logic                      fill_valid_i,
  input  logic [TAG_W-1:0]          fill_tag_i,
  input  logic [WAY_W-1:0]          fill_way_i,
  input  logic [LINE_W-1:0]         fill_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_hit_o,
  output logic [WAY_W-1:0]          rsp_way_o,
  output logic                      rsp_multihit_o,
  output logic [FETCH_W-1:0]        rsp_data_o,
  input  logic                      perf_clr_i,
  output logic [CNT_W-1:0]          hit_cnt_o,
  output logic [CNT_W-1:0]          miss_cnt_o
);

  localparam int unsigned N_CHUNK = LINE_W / FETCH_W;

  logic [0:0]         state_q, state_d;
  logic               accept;
  logic [N_WAY-1:0]   match_c;
  logic [WAY_W-1:0]   enc_idx;
  logic               enc_any, enc_multi;
  logic               byp_c;
  logic [LINE_W-1:0]  sram_line_c, line_c;
  logic               hit_c, multi_c;
  logic [WAY_W-1:0]   way_c;
  logic [FETCH_W-1:0] data_c;

  logic               hit_q, multi_q;
  logic [WAY_W-1:0]   way_q;
  logic [FETCH_W-1:0] data_q;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  assign rsp_valid_o = (state_q == CHK_FULL);
  assign req_ready_o = !flush_i && (!rsp_valid_o || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    match_c = '0;
    for (int i = 0; i < N_WAY; i++) begin
      match_c[i] = way_valid_i[i] && (rd_tags_i[i*TAG_W +: TAG_W] == req_tag_i);
    end
  end

  sargantana_icache_way_prio_enc #(.N(N_WAY)) u_prio_enc (
    .vec_i   (match_c),
    .idx_o   (enc_idx),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  assign byp_c = fill_valid_i && (fill_tag_i == req_tag_i);

  // Refill bypass overrides SRAM; out-of-range chunk index yields zero data.
  always_comb begin
    sram_line_c = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (enc_idx == WAY_W'(i)) sram_line_c = rd_data_i[i*LINE_W +: LINE_W];
    end
    hit_c   = byp_c || enc_any;
    multi_c = !byp_c && enc_multi;
    way_c   = byp_c ? fill_way_i : (enc_any ? enc_idx : '0);
    line_c  = byp_c ? fill_data_i : sram_line_c;
    data_c  = '0;
    if (hit_c) begin
      for (int c = 0; c < N_CHUNK; c++) begin
        if ((N_CHUNK == 1) || (req_idx_i == IDX_W'(c))) data_c = line_c[c*FETCH_W +: FETCH_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_EMPTY: if (accept) state_d = CHK_FULL;
      CHK_FULL:  if (!accept && rsp_ready_i) state_d = CHK_EMPTY;
      default:   state_d = CHK_EMPTY;
    endcase
    if (flush_i) state_d = CHK_EMPTY;
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (perf_clr_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (accept) begin
      if (hit_c && (hit_cnt_q != '1))        hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      else if (!hit_c && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CHK_EMPTY;
      hit_q      <= 1'b0;
      multi_q    <= 1'b0;
      way_q      <= '0;
      data_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (accept) begin
        hit_q   <= hit_c;
        multi_q <= multi_c;
        way_q   <= way_c;
        data_q  <= data_c;
      end
    end
  end

  assign rsp_hit_o      = hit_q;
  assign rsp_multihit_o = multi_q;
  assign rsp_way_o      = way_q;
  assign rsp_data_o     = data_q;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// Self-checking bench for sargantana_icache_checker_pipe: vector table plus
// hold, flush, saturation, counter-clear and reset sequences.
module tb_sargantana_icache_checker_pipe;

  localparam int unsigned N_WAY   = 4;
  localparam int unsigned TAG_W   = 20;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned FETCH_W = 128;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 1;
  localparam int unsigned WAY_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst, flush, req_valid, req_ready;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_idx;
  logic [N_WAY-1:0]        way_valid;
  logic [N_WAY*TAG_W-1:0]  rd_tags;
  logic [N_WAY*LINE_W-1:0] rd_data;
  logic                    fill_valid;
  logic [TAG_W-1:0]        fill_tag;
  logic [WAY_W-1:0]        fill_way;
  logic [LINE_W-1:0]       fill_data;
  logic                    rsp_valid, rsp_ready, rsp_hit, rsp_multihit, perf_clr;
  logic [WAY_W-1:0]        rsp_way;
  logic [FETCH_W-1:0]      rsp_data;
  logic [CNT_W-1:0]        hit_cnt, miss_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sargantana_icache_checker_pipe #(
    .N_WAY(N_WAY), .TAG_W(TAG_W), .LINE_W(LINE_W), .FETCH_W(FETCH_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tag_i(req_tag), .req_idx_i(req_idx),
    .way_valid_i(way_valid), .rd_tags_i(rd_tags), .rd_data_i(rd_data),
    .fill_valid_i(fill_valid), .fill_tag_i(fill_tag), .fill_way_i(fill_way), .fill_data_i(fill_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hit_o(rsp_hit), .rsp_way_o(rsp_way), .rsp_multihit_o(rsp_multihit), .rsp_data_o(rsp_data),
    .perf_clr_i(perf_clr), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  typedef struct packed {
    logic         hit;
    logic         multi;
    logic [1:0]   way;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic [19:0] tag;
    logic        idx;
    logic [3:0]  valid;
    logic [19:0] t0, t1, t2, t3;
    logic        fv;
    logic [19:0] ftag;
    logic [1:0]  fway;
    logic        exp_hit;
    logic        exp_multi;
    logic [1:0]  exp_way;
    int          exp_src;  // way 0..3, 9 = refill line, -1 = no data
  } vec_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  exp_t exp_cur;
  int   m_hit, m_miss;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [255:0] mk_line(input int k);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {8'(k), 8'hC5, 8'(w), 8'h3A};
    return l;
  endfunction

  function automatic logic [127:0] chunk_of(input logic [255:0] l, input logic i);
    return i ? l[255:128] : l[127:0];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    req_tag    = v.tag;
    req_idx    = v.idx;
    way_valid  = v.valid;
    rd_tags    = {v.t3, v.t2, v.t1, v.t0};
    fill_valid = v.fv;
    fill_tag   = v.ftag;
    fill_way   = v.fway;
    exp_cur.hit   = v.exp_hit;
    exp_cur.multi = v.exp_multi;
    exp_cur.way   = v.exp_way;
    exp_cur.data  = (v.exp_src < 0) ? 128'h0 : chunk_of(mk_line(v.exp_src), v.idx);
  endtask

  // One clock: predict handshake, update scoreboard/model, then compare after the edge.
  task automatic cycle();
    logic exp_rdy;
    logic was_rst;
    exp_rdy = !flush && (sb_q.size() == 0 || rsp_ready);
    was_rst = rst;
    #1;
    if (!rst) check("req_ready", 128'(req_ready), 128'(exp_rdy));
    if (rst) begin
      sb_q.delete();
      m_hit  = 0;
      m_miss = 0;
    end else begin
      if (flush) sb_q.delete();
      else if (sb_q.size() != 0 && rsp_ready) void'(sb_q.pop_front());
      if (req_valid && exp_rdy) begin
        sb_q.push_back(exp_cur);
        if (exp_cur.hit) begin
          if (m_hit < CNT_MAX) m_hit++;
        end else if (m_miss < CNT_MAX) m_miss++;
      end
      if (perf_clr) begin
        m_hit  = 0;
        m_miss = 0;
      end
    end
    @(posedge clk);
    #1;
    check("rsp_valid", 128'(rsp_valid), 128'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check("rsp_hit",      128'(rsp_hit),      128'(sb_q[0].hit));
      check("rsp_way",      128'(rsp_way),      128'(sb_q[0].way));
      check("rsp_multihit", 128'(rsp_multihit), 128'(sb_q[0].multi));
      check("rsp_data",     128'(rsp_data),     sb_q[0].data);
    end else if (was_rst) begin
      check("rst_hit",      128'(rsp_hit),      128'h0);
      check("rst_way",      128'(rsp_way),      128'h0);
      check("rst_multihit", 128'(rsp_multihit), 128'h0);
      check("rst_data",     128'(rsp_data),     128'h0);
    end
    check("hit_cnt",  128'(hit_cnt),  128'(m_hit));
    check("miss_cnt", 128'(miss_cnt), 128'(m_miss));
    @(negedge clk);
  endtask

  initial begin
    //            tag       idx valid    t0        t1        t2        t3        fv   ftag      fway  hit  mh   way   src
    vecs[0] = '{20'h12345, 1'b1, 4'b0100, 20'h11111, 20'h22222, 20'h12345, 20'h33333, 1'b0, 20'h0,     2'd0, 1'b1, 1'b0, 2'd2, 2};
    vecs[1] = '{20'h0ABCD, 1'b0, 4'b1111, 20'h11111, 20'h0ABCD, 20'h22222, 20'h0ABCD, 1'b0, 20'h0,     2'd0, 1'b1, 1'b1, 2'd1, 1};
    vecs[2] = '{20'h0ABCD, 1'b0, 4'b1000, 20'h11111, 20'h0ABCD, 20'h22222, 20'h0ABCD, 1'b0, 20'h0,     2'd0, 1'b1, 1'b0, 2'd3, 3};
    vecs[3] = '{20'h0FFFF, 1'b1, 4'b1111, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 1'b0, 20'h0,     2'd0, 1'b0, 1'b0, 2'd0, -1};
    vecs[4] = '{20'h05555, 1'b1, 4'b1111, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 1'b1, 20'h05555, 2'd0, 1'b1, 1'b0, 2'd0, 9};
    vecs[5] = '{20'h0ABCD, 1'b0, 4'b1111, 20'h11111, 20'h0ABCD, 20'h22222, 20'h0ABCD, 1'b1, 20'h0ABCD, 2'd2, 1'b1, 1'b0, 2'd2, 9};
    vecs[6] = '{20'h11111, 1'b0, 4'b0000, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 1'b0, 20'h0,     2'd0, 1'b0, 1'b0, 2'd0, -1};
    vecs[7] = '{20'h12345, 1'b0, 4'b0100, 20'h11111, 20'h22222, 20'h12345, 20'h33333, 1'b1, 20'h0BEEF, 2'd3, 1'b1, 1'b0, 2'd2, 2};
    vecs[8] = '{20'h12345, 1'b1, 4'b1111, 20'h12345, 20'h12345, 20'h12345, 20'h12345, 1'b0, 20'h0,     2'd0, 1'b1, 1'b1, 2'd0, 0};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; perf_clr = 1'b0;
    rd_data   = {mk_line(3), mk_line(2), mk_line(1), mk_line(0)};
    fill_data = mk_line(9);
    apply_vec(vecs[0]);
    m_hit = 0; m_miss = 0;

    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Table, back-to-back at full throughput
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      apply_vec(vecs[i]);
      req_valid = 1'b1;
      cycle();
    end
    req_valid = 1'b0;
    cycle();

    // Miss held for 3 cycles under back-pressure with a pending request
    apply_vec(vecs[3]);
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    cycle();
    apply_vec(vecs[0]);
    repeat (3) cycle();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    cycle();

    // Flush while FULL with a concurrent request
    apply_vec(vecs[0]);
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    cycle();
    flush = 1'b1;
    apply_vec(vecs[1]);
    rsp_ready = 1'b1;
    cycle();
    flush = 1'b0;
    req_valid = 1'b0;
    cycle();

    // Hit counter saturation
    apply_vec(vecs[0]);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && m_hit < CNT_MAX; k++) cycle();
    cycle();
    cycle();
    check("hit_cnt_sat", 128'(hit_cnt), 128'hF);

    // Counter clear beats a concurrent hit
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    check("hit_cnt_clr", 128'(hit_cnt), 128'h0);
    req_valid = 1'b0;
    cycle();

    // Reset mid-stream drops the held response
    apply_vec(vecs[0]);
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
